// File: rtl/gpio_irq_ctrl_if.sv
// Wishbone classic bus bundle between the CPU-side master and gpio_irq_ctrl.
interface gpio_irq_ctrl_if #(
   parameter int WB_AD_WIDTH  = 32,
   parameter int WB_DAT_WIDTH = 32
);
   logic                      wbm_gpio_cyc_i;
   logic                      wbm_gpio_stb_i;
   logic [WB_AD_WIDTH-1:0]    wbm_gpio_addr_i;
   logic [WB_DAT_WIDTH-1:0]   wbm_gpio_wdata_i;
   logic [WB_DAT_WIDTH/8-1:0] wbm_gpio_sel_i;
   logic                      wbm_gpio_we_i;
   logic [WB_DAT_WIDTH-1:0]   gpio_wbm_rdata_o;
   logic                      gpio_wbm_ack_o;

   modport master (
      output wbm_gpio_cyc_i, wbm_gpio_stb_i, wbm_gpio_addr_i,
             wbm_gpio_wdata_i, wbm_gpio_sel_i, wbm_gpio_we_i,
      input  gpio_wbm_rdata_o, gpio_wbm_ack_o
   );

   modport slave (
      input  wbm_gpio_cyc_i, wbm_gpio_stb_i, wbm_gpio_addr_i,
             wbm_gpio_wdata_i, wbm_gpio_sel_i, wbm_gpio_we_i,
      output gpio_wbm_rdata_o, gpio_wbm_ack_o
   );
endinterface

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt front end: pin synchronizer, per-pin level/edge detect,
// pending latch, level IRQ to the PLIC, and a Wishbone register port.
module gpio_irq_ctrl #(
   parameter int GPIO_NUM     = 16,
   parameter int WB_AD_WIDTH  = 32,
   parameter int WB_DAT_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [GPIO_NUM-1:0] gpio_pins_i,
   gpio_irq_ctrl_if.slave      wb,
   output logic                gpio_plic_irq_o
);

   typedef enum logic [2:0] {
      REG_DATA_IN     = 3'd0,
      REG_IRQ_EN      = 3'd1,
      REG_IRQ_TYPE    = 3'd2,
      REG_IRQ_POL     = 3'd3,
      REG_IRQ_BOTH    = 3'd4,
      REG_IRQ_PENDING = 3'd5,
      REG_IRQ_STATUS  = 3'd6,
      REG_RESERVED    = 3'd7
   } reg_e;

   logic [GPIO_NUM-1:0]     s1, s2, s2_d;
   logic [1:0]              warm;
   logic                    edge_ok;
   logic [GPIO_NUM-1:0]     irq_en, irq_type, irq_pol, irq_both;
   logic [GPIO_NUM-1:0]     pending, hit, w1c;
   logic [GPIO_NUM-1:0]     wbits, wmask, rd_val;
   logic [WB_DAT_WIDTH-1:0] lane_mask;
   logic                    ack_ff, access, wr;
   reg_e                    reg_sel;
   logic                    unused_bits;

   assign reg_sel = reg_e'(wb.wbm_gpio_addr_i[4:2]);
   assign access  = wb.wbm_gpio_cyc_i & wb.wbm_gpio_stb_i & ~ack_ff;
   assign wr      = access & wb.wbm_gpio_we_i;
   assign wbits   = wb.wbm_gpio_wdata_i[GPIO_NUM-1:0];
   assign wmask   = lane_mask[GPIO_NUM-1:0];
   assign edge_ok = (warm == 2'd3);
   assign w1c     = (wr && reg_sel == REG_IRQ_PENDING) ? (wbits & wmask) : '0;
   assign wb.gpio_wbm_ack_o = ack_ff & wb.wbm_gpio_cyc_i;

   // Address bits outside [4:2] and data bits above GPIO_NUM are don't-care.
   assign unused_bits = ^{wb.wbm_gpio_addr_i, wb.wbm_gpio_wdata_i, lane_mask};

   function automatic logic [GPIO_NUM-1:0] merge(input logic [GPIO_NUM-1:0] old,
                                                 input logic [GPIO_NUM-1:0] data,
                                                 input logic [GPIO_NUM-1:0] mask);
      return (old & ~mask) | (data & mask);
   endfunction

   // Expand byte enables into a per-bit write mask.
   always_comb begin
      lane_mask = '0;
      for (int unsigned i = 0; i < WB_DAT_WIDTH / 8; i++)
         lane_mask[i*8 +: 8] = {8{wb.wbm_gpio_sel_i[i]}};
   end

   // Two-flop synchronizer, previous-sample flop and edge warm-up counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= '0;
         s2   <= '0;
         s2_d <= '0;
         warm <= '0;
      end else begin
         s1   <= gpio_pins_i;
         s2   <= s1;
         s2_d <= s2;
         if (warm != 2'd3)
            warm <= warm + 2'd1;
      end
   end

   // Per-pin detect condition; edges are masked until the pipeline has filled.
   always_comb begin
      hit = '0;
      for (int unsigned i = 0; i < GPIO_NUM; i++) begin
         if (!irq_type[i])
            hit[i] = (s2[i] == irq_pol[i]);
         else if (irq_both[i])
            hit[i] = edge_ok & (s2[i] ^ s2_d[i]);
         else if (irq_pol[i])
            hit[i] = edge_ok & s2[i] & ~s2_d[i];
         else
            hit[i] = edge_ok & ~s2[i] & s2_d[i];
      end
   end

   // Configuration registers written through the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_en   <= '0;
         irq_type <= '0;
         irq_pol  <= '1;
         irq_both <= '0;
      end else if (wr) begin
         case (reg_sel)
            REG_IRQ_EN:   irq_en   <= merge(irq_en,   wbits, wmask);
            REG_IRQ_TYPE: irq_type <= merge(irq_type, wbits, wmask);
            REG_IRQ_POL:  irq_pol  <= merge(irq_pol,  wbits, wmask);
            REG_IRQ_BOTH: irq_both <= merge(irq_both, wbits, wmask);
            default: ;
         endcase
      end
   end

   // Pending latch (a new hit beats a same-cycle clear) and the IRQ level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending         <= '0;
         gpio_plic_irq_o <= 1'b0;
      end else begin
         pending         <= (pending & ~w1c) | hit;
         gpio_plic_irq_o <= |(pending & irq_en);
      end
   end

   // Read multiplexer.
   always_comb begin
      rd_val = '0;
      case (reg_sel)
         REG_DATA_IN:     rd_val = s2;
         REG_IRQ_EN:      rd_val = irq_en;
         REG_IRQ_TYPE:    rd_val = irq_type;
         REG_IRQ_POL:     rd_val = irq_pol;
         REG_IRQ_BOTH:    rd_val = irq_both;
         REG_IRQ_PENDING: rd_val = pending;
         REG_IRQ_STATUS:  rd_val = pending & irq_en;
         default:         rd_val = '0;
      endcase
   end

   // Single-cycle ack and registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_ff              <= 1'b0;
         wb.gpio_wbm_rdata_o <= '0;
      end else begin
         ack_ff <= access;
         if (access)
            wb.gpio_wbm_rdata_o <= WB_DAT_WIDTH'(rd_val);
      end
   end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: register access, detection modes and IRQ timing.
module tb_gpio_irq_ctrl;

   localparam logic [31:0] A_DATA = 32'h00, A_EN = 32'h04, A_TYPE = 32'h08,
                           A_POL = 32'h0C, A_BOTH = 32'h10, A_PEND = 32'h14,
                           A_STAT = 32'h18, A_RSVD = 32'h1C;

   logic        clk;
   logic        rst;
   logic [15:0] pins;
   logic        irq;
   logic [31:0] rd;
   int          tests;
   int          failed;

   gpio_irq_ctrl_if #(.WB_AD_WIDTH(32), .WB_DAT_WIDTH(32)) wb ();

   gpio_irq_ctrl #(.GPIO_NUM(16), .WB_AD_WIDTH(32), .WB_DAT_WIDTH(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .gpio_pins_i     (pins),
      .wb              (wb.slave),
      .gpio_plic_irq_o (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] sel, output logic [31:0] rdata);
      int n;
      wb.wbm_gpio_cyc_i   = 1'b1;
      wb.wbm_gpio_stb_i   = 1'b1;
      wb.wbm_gpio_we_i    = we;
      wb.wbm_gpio_addr_i  = addr;
      wb.wbm_gpio_wdata_i = data;
      wb.wbm_gpio_sel_i   = sel;
      n = 0;
      do begin
         tick();
         n++;
      end while (wb.gpio_wbm_ack_o !== 1'b1 && n < 4);
      check("bus_ack", {31'd0, wb.gpio_wbm_ack_o}, 32'd1);
      rdata = wb.gpio_wbm_rdata_o;
      wb.wbm_gpio_cyc_i = 1'b0;
      wb.wbm_gpio_stb_i = 1'b0;
      wb.wbm_gpio_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] d;
      bus(1'b1, addr, data, 4'hF, d);
      tick();
   endtask

   task automatic rdreg(input logic [31:0] addr, output logic [31:0] data);
      bus(1'b0, addr, 32'd0, 4'hF, data);
      tick();
   endtask

   initial begin
      tests  = 0;
      failed = 0;
      rst    = 1'b1;
      pins   = 16'h0008;
      wb.wbm_gpio_cyc_i   = 1'b0;
      wb.wbm_gpio_stb_i   = 1'b0;
      wb.wbm_gpio_we_i    = 1'b0;
      wb.wbm_gpio_addr_i  = '0;
      wb.wbm_gpio_wdata_i = '0;
      wb.wbm_gpio_sel_i   = '0;

      // Reset with pin 3 held high
      repeat (3) tick();
      check("rst_ack", {31'd0, wb.gpio_wbm_ack_o}, 32'd0);
      check("rst_rdata", wb.gpio_wbm_rdata_o, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      rst = 1'b0;
      repeat (5) tick();
      // default config is level-high, so the held pin is pending already
      rdreg(A_PEND, rd);  check("default_level_pend", rd, 32'h0008);
      wr(A_TYPE, 32'h0008);
      wr(A_PEND, 32'h0008);
      wr(A_EN,   32'h0008);
      repeat (4) tick();
      rdreg(A_PEND, rd);  check("held_pin_no_edge", rd, 32'h0000);
      check("held_pin_irq", {31'd0, irq}, 32'd0);
      rdreg(A_DATA, rd);  check("data_in_pin3", rd, 32'h0008);

      // Rising edge on pin 0 and pin-to-IRQ latency
      wr(A_TYPE, 32'h0009);
      wr(A_EN,   32'h0001);
      pins[0] = 1'b1;
      tick();  // N
      tick();  // N+1
      tick();  // N+2
      check("rise_irq_n2", {31'd0, irq}, 32'd0);
      tick();  // N+3
      check("rise_irq_n3", {31'd0, irq}, 32'd1);
      rdreg(A_PEND, rd);  check("rise_pend", rd, 32'h0001);
      bus(1'b1, A_PEND, 32'h0001, 4'hF, rd);
      check("clr_irq_at_ack", {31'd0, irq}, 32'd1);
      tick();
      check("clr_irq_after", {31'd0, irq}, 32'd0);

      // Active-low level on pin 5
      wr(A_POL, 32'hFFDF);
      wr(A_EN,  32'h0020);
      repeat (2) tick();
      check("lvl_irq", {31'd0, irq}, 32'd1);
      wr(A_PEND, 32'h0020);
      rdreg(A_PEND, rd);  check("lvl_no_clear", rd, 32'h0020);
      pins[5] = 1'b1;
      repeat (4) tick();
      wr(A_PEND, 32'h0020);
      check("lvl_irq_clr", {31'd0, irq}, 32'd0);
      rdreg(A_PEND, rd);  check("lvl_pend_clr", rd, 32'h0000);

      // Both edges on pin 1, clear colliding with the set
      wr(A_EN,   32'h0002);
      wr(A_BOTH, 32'h0002);
      wr(A_TYPE, 32'h000B);
      pins[1] = 1'b1;
      tick();
      tick();
      bus(1'b1, A_PEND, 32'h0002, 4'hF, rd);  // this edge coincides with the set
      tick();
      rdreg(A_PEND, rd);  check("set_wins", rd, 32'h0002);
      check("both_irq", {31'd0, irq}, 32'd1);
      wr(A_PEND, 32'h0002);
      rdreg(A_PEND, rd);  check("both_cleared", rd, 32'h0000);
      pins[1] = 1'b0;
      repeat (4) tick();
      rdreg(A_PEND, rd);  check("both_fall", rd, 32'h0002);
      wr(A_PEND, 32'h0002);

      // Masked pending on pin 7, then enable
      wr(A_EN,   32'h0000);
      wr(A_TYPE, 32'h008B);
      pins[7] = 1'b1;
      repeat (4) tick();
      rdreg(A_PEND, rd);  check("mask_pend", rd, 32'h0080);
      rdreg(A_STAT, rd);  check("mask_status", rd, 32'h0000);
      check("mask_irq", {31'd0, irq}, 32'd0);
      bus(1'b1, A_EN, 32'h0080, 4'hF, rd);
      check("en_irq_at_ack", {31'd0, irq}, 32'd0);
      tick();
      check("en_irq_next", {31'd0, irq}, 32'd1);
      rdreg(A_STAT, rd);  check("en_status", rd, 32'h0080);

      // Held strobe on the reserved address
      wb.wbm_gpio_cyc_i  = 1'b1;
      wb.wbm_gpio_stb_i  = 1'b1;
      wb.wbm_gpio_we_i   = 1'b0;
      wb.wbm_gpio_addr_i = A_RSVD;
      tick();
      check("hold_ack1", {31'd0, wb.gpio_wbm_ack_o}, 32'd1);
      check("rsvd_rdata", wb.gpio_wbm_rdata_o, 32'd0);
      tick();
      check("hold_ack2", {31'd0, wb.gpio_wbm_ack_o}, 32'd0);
      tick();
      tick();
      wb.wbm_gpio_cyc_i = 1'b0;
      wb.wbm_gpio_stb_i = 1'b0;
      tick();

      // Dropping cyc cancels the ack
      wb.wbm_gpio_cyc_i  = 1'b1;
      wb.wbm_gpio_stb_i  = 1'b1;
      wb.wbm_gpio_addr_i = A_DATA;
      tick();
      wb.wbm_gpio_cyc_i = 1'b0;
      wb.wbm_gpio_stb_i = 1'b0;
      #1;
      check("cyc_drop_ack", {31'd0, wb.gpio_wbm_ack_o}, 32'd0);
      tick();

      // Byte lanes, out-of-range bits and read-only writes
      bus(1'b1, A_EN, 32'h0000FFFF, 4'b0001, rd);
      tick();
      rdreg(A_EN, rd);    check("sel_lane0", rd, 32'h00FF);
      wr(A_BOTH, 32'hFFFFFFFF);
      rdreg(A_BOTH, rd);  check("upper_bits_zero", rd, 32'h0000FFFF);
      wr(A_DATA, 32'h00001234);
      rdreg(A_DATA, rd);  check("data_in_ro", rd, 32'h00A9);
      rdreg(A_POL, rd);   check("pol_keep", rd, 32'hFFDF);
      wr(A_STAT, 32'h00000000);
      rdreg(A_STAT, rd);  check("status_ro", rd, 32'h0080);

      // Reset during an acked read
      wb.wbm_gpio_cyc_i  = 1'b1;
      wb.wbm_gpio_stb_i  = 1'b1;
      wb.wbm_gpio_addr_i = A_EN;
      tick();
      check("pre_rst_ack", {31'd0, wb.gpio_wbm_ack_o}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_ack", {31'd0, wb.gpio_wbm_ack_o}, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);
      check("midrst_rdata", wb.gpio_wbm_rdata_o, 32'd0);
      wb.wbm_gpio_cyc_i = 1'b0;
      wb.wbm_gpio_stb_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/gpio_irq_ctrl.md
# gpio_irq_ctrl

GPIO interrupt front end that synchronizes raw GPIO input pins, detects level or edge conditions per pin, and latches them into a pending register. It drives the single `gpio_plic_irq_o` line consumed by the PLIC's GPIO gateway (source ID 2). A Wishbone slave port lets software configure detection, read pin state and clear pending bits. The output is a level that stays high until software clears the cause, matching the PLIC gateway's claim/complete blocking.

## Interface
Parameters:
- `GPIO_NUM`, 16: number of input pins (1..32).
- `WB_AD_WIDTH`, 32: Wishbone address width.
- `WB_DAT_WIDTH`, 32: Wishbone data width.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `gpio_pins_i` in GPIO_NUM: raw asynchronous pin inputs.
- `wbm_gpio_cyc_i` in 1: Wishbone cycle.
- `wbm_gpio_stb_i` in 1: Wishbone strobe.
- `wbm_gpio_addr_i` in WB_AD_WIDTH: byte address; only bits [4:2] are decoded.
- `wbm_gpio_wdata_i` in WB_DAT_WIDTH: write data.
- `wbm_gpio_sel_i` in WB_DAT_WIDTH/8: byte enables, applied to writes.
- `wbm_gpio_we_i` in 1: 1 = write.
- `gpio_wbm_rdata_o` out WB_DAT_WIDTH: registered read data.
- `gpio_wbm_ack_o` out 1: registered single-cycle acknowledge.
- `gpio_plic_irq_o` out 1: registered interrupt request to the PLIC.

## Operation
- **Synchronizer:** two flops per pin, `s1` then `s2`. A third flop `s2_d` holds the previous `s2`.
- **Warm-up counter:** a 2-bit counter, reset to 0, saturates at 3. Edge detection is suppressed until the counter reaches 3, so pins that are already high at reset do not raise spurious edges. Level detection is not suppressed.
- **Per-pin condition (`hit`):**
  - TYPE=0 (level): `hit = (s2 == POL)`.
  - TYPE=1 (edge), BOTH=1: `hit = s2 ^ s2_d`.
  - TYPE=1 (edge), BOTH=0, POL=1: `hit = s2 & ~s2_d`.
  - TYPE=1 (edge), BOTH=0, POL=0: `hit = ~s2 & s2_d`.
- **Pending register:**
  - `pending <= (pending & ~w1c) | hit`. Set wins over a same-cycle W1C.
  - Pending captures regardless of IRQ_EN.
  - A level source cannot be cleared while its condition holds.
- **Output:** `gpio_plic_irq_o <= |(pending & IRQ_EN)`.
- **Register map** (offset = addr[4:2]×4). All registers are GPIO_NUM bits wide, zero-extended on read.
  - 0x00 DATA_IN: RO, the `s2` value.
  - 0x04 IRQ_EN: RW, reset 0.
  - 0x08 IRQ_TYPE: RW, reset 0.
  - 0x0C IRQ_POL: RW, reset all-ones.
  - 0x10 IRQ_BOTH: RW, reset 0.
  - 0x14 IRQ_PENDING: read returns pending; write-1-to-clear.
  - 0x18 IRQ_STATUS: RO, `pending & IRQ_EN`.
  - 0x1C: reserved; reads 0, writes ignored, still acked.
- **Write rules:**
  - Byte lanes with `sel=0` are unchanged.
  - Writes to RO registers are acked and ignored.
  - Bits at or above GPIO_NUM are ignored on write and read as 0.
- **Config changes:** changing TYPE, POL or BOTH never clears pending bits retroactively.

## Timing
- **Reset values:**
  - `gpio_wbm_ack_o` = 0, `gpio_wbm_rdata_o` = 0, `gpio_plic_irq_o` = 0.
  - `pending`, `s1`, `s2`, `s2_d` and the warm-up counter = 0.
- **Reset mid-operation:** an asserted `rst` immediately clears all state, including an in-flight ack.
- **Bus handshake:**
  - `ack_ff <= cyc & stb & ~ack_ff`, and `gpio_wbm_ack_o = ack_ff & cyc`.
  - One access takes 2 cycles. Ack goes high in the cycle after `stb` is first seen, and lasts exactly 1 cycle even if `stb` is held.
  - Back-to-back accesses therefore complete at most every 2 cycles.
  - Read data is valid in the ack cycle.
  - A write takes effect at the clock edge that raises ack.
  - Dropping `cyc` cancels ack output.
- **Pin-to-IRQ latency:** a pin change sampled at edge N reaches `s2` at N+1, sets pending at N+2, and drives `gpio_plic_irq_o` high at N+3.
- **Pulse width:** input pulses shorter than 1 clk may be missed. Pulses of 2 clk or more are always captured.
- **Clear-to-deassert:** a W1C that clears the last enabled pending bit at edge M drops `gpio_plic_irq_o` at M+1.
- **Register-to-IRQ:** an IRQ_EN write at edge M affects `gpio_plic_irq_o` at M+1.

## Test plan
- **Reset with pins high:** hold pin 3 high through reset, then set EN=0x8, TYPE=0x8, POL=0x8 (rising edge). Required: pending stays 0 and irq stays 0.
- **Rising edge:** EN=0x1, TYPE=0x1, POL=0x1; drive pin0 0→1 at edge N. Required: pending=0x1 after N+2 and irq=1 at N+3. W1C 0x1 to 0x14: irq=0 one cycle after ack.
- **Level low, active:** TYPE=0, POL=0 for pin 5, EN=0x20, pin5 held low. Required: W1C 0x20 is acked but pending stays 0x20. After driving pin5 high and writing W1C, pending=0 and irq=0.
- **Both edges with simultaneous clear:** BOTH=0x2, TYPE=0x2; toggle pin1 in the same cycle as a W1C of 0x2. Required: pending[1]=1, because set wins.
- **Masked pending:** edge on pin 7 with EN=0. Required: PENDING=0x80, STATUS=0, irq=0. Then write EN=0x80: irq=1 next cycle.
- **Bus protocol:** hold stb for 4 cycles on a read of 0x1C. Required: ack pulses for 1 cycle and reads 0. A write with sel=4'b0001 of 0xFFFF to 0x04 gives EN=0x00FF.
